// File: rtl/synth_cfg_pkg.sv
// Shared constants for the synth configuration word: frame width, field
// positions inside the 60-bit word, and the SPI master state encoding.
package synth_cfg_pkg;

  localparam int CFG_WIDTH = 60;

  localparam int ADSR_AI_LSB   = 0;
  localparam int ADSR_AI_W     = 8;
  localparam int ADSR_DI_LSB   = 8;
  localparam int ADSR_DI_W     = 8;
  localparam int ADSR_S_LSB    = 16;
  localparam int ADSR_S_W      = 8;
  localparam int ADSR_RI_LSB   = 24;
  localparam int ADSR_RI_W     = 8;
  localparam int OSC_COUNT_LSB = 32;
  localparam int OSC_COUNT_W   = 12;
  localparam int FILTER_A_LSB  = 44;
  localparam int FILTER_A_W    = 8;
  localparam int FILTER_B_LSB  = 52;
  localparam int FILTER_B_W    = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } state_e;

  // Width of a down-counter that must hold values 0..n without wrapping.
  function automatic int cnt_w(input int n);
    int w;
    w = $clog2(n + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/spi_cfg_master_if.sv
// Config-word handshake plus SPI pins of the synth config master.
// "master" is the block side, "slave" the host/receiver side.
interface spi_cfg_master_if #(
  parameter int WIDTH = 60
);
  logic [WIDTH-1:0] cfg_data;
  logic             cfg_valid;
  logic             cfg_ready;
  logic             busy;
  logic             done;
  logic             sclk;
  logic             mosi;
  logic             nss;

  modport master (
    input  cfg_data, cfg_valid,
    output cfg_ready, busy, done, sclk, mosi, nss
  );

  modport slave (
    output cfg_data, cfg_valid,
    input  cfg_ready, busy, done, sclk, mosi, nss
  );
endinterface

// File: rtl/spi_cfg_master.sv
// Serializes one synth config word per handshake onto sclk/mosi/nss, MSB first,
// with an optional nss-low hold after the last bit and a minimum nss-high gap.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | cfg_ready=1, waiting for cfg_valid
// ST_SETUP | nss low, sclk low for DIV cycles, first bit on mosi
// ST_SHIFT | WIDTH bit periods: sclk high DIV, then low DIV
// ST_HOLD  | nss low, sclk parked low for HOLD_CYC cycles
// ST_GAP   | nss high for DIV cycles, done on the last one
module spi_cfg_master
  import synth_cfg_pkg::*;
#(
  parameter int WIDTH    = CFG_WIDTH,
  parameter int DIV      = 4,
  parameter int HOLD_CYC = 0
) (
  input  logic              clk,
  input  logic              arstn,
  spi_cfg_master_if.master  bus
);

  localparam int PH_W   = cnt_w(DIV);
  localparam int BIT_W  = cnt_w(WIDTH);
  localparam int HOLD_W = cnt_w(HOLD_CYC);

  localparam logic [PH_W-1:0]   PH_LOAD   = PH_W'(DIV - 1);
  localparam logic [BIT_W-1:0]  BIT_LOAD  = BIT_W'(WIDTH - 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);

  state_e             state_q, state_d;
  logic [PH_W-1:0]    ph_q, ph_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [WIDTH-1:0]   sh_q, sh_d;
  logic               sclk_q, sclk_d;
  logic               mosi_q, mosi_d;
  logic               nss_q, nss_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               go_gap;

  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    bit_d   = bit_q;
    hold_d  = hold_q;
    sh_d    = sh_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    nss_d   = nss_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    go_gap  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.cfg_valid && ready_q) begin
          sh_d    = bus.cfg_data;
          mosi_d  = bus.cfg_data[WIDTH-1];
          nss_d   = 1'b0;
          ready_d = 1'b0;
          busy_d  = 1'b1;
          ph_d    = PH_LOAD;
          bit_d   = BIT_LOAD;
          state_d = ST_SETUP;
        end
      end

      ST_SETUP: begin
        if (ph_q == '0) begin
          sclk_d  = 1'b1;
          ph_d    = PH_LOAD;
          state_d = ST_SHIFT;
        end else begin
          ph_d = ph_q - PH_W'(1);
        end
      end

      ST_SHIFT: begin
        if (ph_q != '0) begin
          ph_d = ph_q - PH_W'(1);
        end else if (sclk_q) begin
          sclk_d = 1'b0;
          ph_d   = PH_LOAD;
          // the last bit stays on mosi through hold; no shift after bit 0
          if (bit_q != '0) begin
            sh_d   = {sh_q[WIDTH-2:0], 1'b0};
            mosi_d = sh_q[WIDTH-2];
          end
        end else if (bit_q != '0) begin
          bit_d  = bit_q - BIT_W'(1);
          sclk_d = 1'b1;
          ph_d   = PH_LOAD;
        end else if (HOLD_CYC > 0) begin
          hold_d  = HOLD_LOAD;
          state_d = ST_HOLD;
        end else begin
          go_gap = 1'b1;
        end
      end

      ST_HOLD: begin
        if (hold_q != '0) hold_d = hold_q - HOLD_W'(1);
        else              go_gap = 1'b1;
      end

      ST_GAP: begin
        if (ph_q != '0) begin
          ph_d   = ph_q - PH_W'(1);
          done_d = (ph_q == PH_W'(1));
        end else begin
          ready_d = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // done is registered, so it is launched when entering the final GAP cycle
    if (go_gap) begin
      nss_d   = 1'b1;
      mosi_d  = 1'b0;
      ph_d    = PH_LOAD;
      done_d  = (DIV == 1);
      state_d = ST_GAP;
    end
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q <= ST_IDLE;
      ph_q    <= '0;
      bit_q   <= '0;
      hold_q  <= '0;
      sh_q    <= '0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      nss_q   <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      bit_q   <= bit_d;
      hold_q  <= hold_d;
      sh_q    <= sh_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      nss_q   <= nss_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.sclk      = sclk_q;
  assign bus.mosi      = mosi_q;
  assign bus.nss       = nss_q;
  assign bus.cfg_ready = ready_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_spi_cfg_master.sv
// Bench for spi_cfg_master: two instances (DIV=3 no hold, DIV=2 long hold) each
// observed by a behavioural SPI receiver model sampling on the falling clk edge.
module tb_spi_cfg_master;
  import synth_cfg_pkg::*;

  localparam int W     = 60;
  localparam int DIV0  = 3;
  localparam int DIV1  = 2;
  localparam int HOLD1 = 1000;

  logic clk = 1'b0;
  logic arstn = 1'b0;
  always #5 clk = ~clk;

  spi_cfg_master_if #(.WIDTH(W)) if0 ();
  spi_cfg_master_if #(.WIDTH(W)) if1 ();

  spi_cfg_master #(.WIDTH(W), .DIV(DIV0), .HOLD_CYC(0)) u_dut0 (
    .clk(clk), .arstn(arstn), .bus(if0.master));
  spi_cfg_master #(.WIDTH(W), .DIV(DIV1), .HOLD_CYC(HOLD1)) u_dut1 (
    .clk(clk), .arstn(arstn), .bus(if1.master));

  logic sclk_w[2], mosi_w[2], nss_w[2], done_w[2];
  assign sclk_w[0] = if0.sclk;  assign sclk_w[1] = if1.sclk;
  assign mosi_w[0] = if0.mosi;  assign mosi_w[1] = if1.mosi;
  assign nss_w[0]  = if0.nss;   assign nss_w[1]  = if1.nss;
  assign done_w[0] = if0.done;  assign done_w[1] = if1.done;

  // receiver model state
  int          cyc = 0;
  int          low_len[2], edges[2], last_tog[2], high_run[2], gap_len[2];
  int          end_len[2], end_edges[2], end_tog[2], end_cnt[2], fall_cnt[2];
  int          fall_cyc[2], acc_int[2];
  int          viol_mosi[2], viol_sclk[2], viol_done[2], done_cnt[2];
  logic [W-1:0] rx[2];
  logic        ps[2] = '{1'b0, 1'b0};
  logic        pm[2] = '{1'b0, 1'b0};
  logic        pn[2] = '{1'b1, 1'b1};
  logic [W-1:0] fq0[$];
  logic [W-1:0] fq1[$];

  initial begin
    for (int i = 0; i < 2; i++) begin
      low_len[i] = 0; edges[i] = 0; last_tog[i] = 0; high_run[i] = 0; gap_len[i] = 0;
      end_len[i] = 0; end_edges[i] = 0; end_tog[i] = 0; end_cnt[i] = 0; fall_cnt[i] = 0;
      fall_cyc[i] = 0; acc_int[i] = 0; viol_mosi[i] = 0; viol_sclk[i] = 0;
      viol_done[i] = 0; done_cnt[i] = 0; rx[i] = '0;
    end
  end

  always @(negedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 2; i++) begin
      ps[i] <= sclk_w[i];
      pm[i] <= mosi_w[i];
      pn[i] <= nss_w[i];
      if (done_w[i]) begin
        done_cnt[i] <= done_cnt[i] + 1;
        if (!nss_w[i]) viol_done[i] <= viol_done[i] + 1;
      end
      if (nss_w[i] && sclk_w[i]) viol_sclk[i] <= viol_sclk[i] + 1;
      if (!nss_w[i]) begin
        if (pn[i]) begin
          low_len[i]  <= 1;
          edges[i]    <= 0;
          last_tog[i] <= 0;
          rx[i]       <= '0;
          gap_len[i]  <= high_run[i];
          fall_cnt[i] <= fall_cnt[i] + 1;
          acc_int[i]  <= cyc - fall_cyc[i];
          fall_cyc[i] <= cyc;
        end else begin
          low_len[i] <= low_len[i] + 1;
          if (sclk_w[i] != ps[i]) last_tog[i] <= low_len[i] + 1;
          if (sclk_w[i] && !ps[i]) begin
            edges[i] <= edges[i] + 1;
            rx[i]    <= {rx[i][W-2:0], mosi_w[i]};
          end
          if (sclk_w[i] && (mosi_w[i] != pm[i])) viol_mosi[i] <= viol_mosi[i] + 1;
        end
      end else begin
        if (!pn[i]) begin
          end_len[i]   <= low_len[i];
          end_edges[i] <= edges[i];
          end_tog[i]   <= last_tog[i];
          end_cnt[i]   <= end_cnt[i] + 1;
          high_run[i]  <= 1;
          if (edges[i] == W) begin
            if (i == 0) fq0.push_back(rx[i]);
            else        fq1.push_back(rx[i]);
          end
        end else begin
          high_run[i] <= high_run[i] + 1;
        end
      end
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic rdy(input int i);
    return (i == 0) ? if0.cfg_ready : if1.cfg_ready;
  endfunction

  function automatic logic [63:0] field(input logic [W-1:0] w, input int lsb, input int wd);
    logic [63:0] v;
    v = 64'(w) >> lsb;
    return v & ((64'd1 << wd) - 64'd1);
  endfunction

  function automatic logic [W-1:0] rand_word();
    logic [63:0] v;
    v = {$urandom, $urandom};
    return v[W-1:0];
  endfunction

  task automatic drive(input int i, input logic v, input logic [W-1:0] w);
    if (i == 0) begin if0.cfg_valid = v; if0.cfg_data = w; end
    else        begin if1.cfg_valid = v; if1.cfg_data = w; end
  endtask

  // Offer a word, wait for acceptance, then drop valid; returns at the
  // falling edge just after the accepting rising edge.
  task automatic send(input int i, input logic [W-1:0] w);
    int k = 0;
    @(negedge clk);
    drive(i, 1'b1, w);
    while (!rdy(i) && k < 3000) begin @(negedge clk); k++; end
    chk("accept_timeout", 64'(k < 3000), 64'd1);
    @(negedge clk);
    drive(i, 1'b0, rand_word());
  endtask

  task automatic wait_end(input int i, input int target, input int limit);
    int k = 0;
    while (end_cnt[i] < target && k < limit) begin @(negedge clk); k++; end
    chk("frame_end_timeout", 64'(k < limit), 64'd1);
    repeat (8) @(negedge clk);
  endtask

  task automatic check_frame0(input string tag, input logic [W-1:0] w);
    logic [W-1:0] got;
    chk({tag, "_count"}, 64'(fq0.size()), 64'd1);
    if (fq0.size() > 0) begin
      got = fq0.pop_front();
      chk({tag, "_word"}, 64'(got), 64'(w));
    end
    chk({tag, "_nss_low"}, 64'(end_len[0]), 64'(DIV0 + 2 * DIV0 * W));
    chk({tag, "_edges"}, 64'(end_edges[0]), 64'(W));
    chk({tag, "_mosi_stable"}, 64'(viol_mosi[0]), 64'd0);
  endtask

  logic [W-1:0] wa, wb;
  int done0_exp = 0;
  int fc;

  initial begin
    drive(0, 1'b0, '0);
    drive(1, 1'b0, '0);
    repeat (3) @(negedge clk);
    chk("rst_sclk",  64'(if0.sclk), 64'd0);
    chk("rst_mosi",  64'(if0.mosi), 64'd0);
    chk("rst_nss",   64'(if0.nss), 64'd1);
    chk("rst_ready", 64'(if0.cfg_ready), 64'd1);
    chk("rst_busy",  64'(if0.busy), 64'd0);
    chk("rst_done",  64'(if0.done), 64'd0);
    arstn = 1'b1;
    repeat (2) @(negedge clk);

    // basic frames with random words, including first-cycle checks
    for (int n = 0; n < 4; n++) begin
      wa = rand_word();
      send(0, wa);
      chk("start_nss",   64'(if0.nss), 64'd0);
      chk("start_ready", 64'(if0.cfg_ready), 64'd0);
      chk("start_busy",  64'(if0.busy), 64'd1);
      chk("start_mosi",  64'(if0.mosi), 64'(wa[W-1]));
      wait_end(0, end_cnt[0] + 1, 3000);
      done0_exp++;
      check_frame0("frame", wa);
      chk("done_count", 64'(done_cnt[0]), 64'(done0_exp));
    end

    // valid pulsed mid-frame with another word must be ignored
    wa = rand_word();
    wb = ~wa;
    send(0, wa);
    repeat (100) @(negedge clk);
    chk("mid_ready", 64'(if0.cfg_ready), 64'd0);
    drive(0, 1'b1, wb);
    @(negedge clk);
    chk("mid_ready_held", 64'(if0.cfg_ready), 64'd0);
    drive(0, 1'b0, wb);
    wait_end(0, end_cnt[0] + 1, 3000);
    done0_exp++;
    check_frame0("ignore", wa);
    fc = fall_cnt[0];
    repeat (20) @(negedge clk);
    chk("ignore_no_new_frame", 64'(fall_cnt[0]), 64'(fc));
    chk("ignore_nss_idle", 64'(if0.nss), 64'd1);

    // valid held high: A then B back-to-back
    wa = rand_word();
    wb = rand_word();
    fc = end_cnt[0];
    @(negedge clk);
    drive(0, 1'b1, wa);
    begin
      int k = 0;
      while (rdy(0) && k < 10) begin @(negedge clk); k++; end
      drive(0, 1'b1, wb);
      k = 0;
      while (!rdy(0) && k < 3000) begin @(negedge clk); k++; end
      chk("b2b_ready_timeout", 64'(k < 3000), 64'd1);
      @(negedge clk);
      drive(0, 1'b0, rand_word());
    end
    wait_end(0, fc + 2, 3000);
    done0_exp += 2;
    chk("b2b_count", 64'(fq0.size()), 64'd2);
    if (fq0.size() == 2) begin
      chk("b2b_word_a", 64'(fq0.pop_front()), 64'(wa));
      chk("b2b_word_b", 64'(fq0.pop_front()), 64'(wb));
    end
    chk("b2b_gap", 64'(gap_len[0]), 64'(DIV0 + 1));
    chk("b2b_accept_interval", 64'(acc_int[0]), 64'(1 + DIV0 + 2 * DIV0 * W + DIV0));
    chk("done_count_b2b", 64'(done_cnt[0]), 64'(done0_exp));

    // asynchronous reset after 10 bits
    wa = rand_word();
    send(0, wa);
    begin
      int k = 0;
      while (edges[0] < 10 && k < 3000) begin @(negedge clk); k++; end
      chk("rst_wait_timeout", 64'(k < 3000), 64'd1);
    end
    #2 arstn = 1'b0;
    #1;
    chk("arst_nss",   64'(if0.nss), 64'd1);
    chk("arst_sclk",  64'(if0.sclk), 64'd0);
    chk("arst_mosi",  64'(if0.mosi), 64'd0);
    chk("arst_ready", 64'(if0.cfg_ready), 64'd1);
    chk("arst_busy",  64'(if0.busy), 64'd0);
    chk("arst_done",  64'(if0.done), 64'd0);
    @(negedge clk);
    @(negedge clk);
    arstn = 1'b1;
    repeat (2) @(negedge clk);
    chk("arst_partial_dropped", 64'(fq0.size()), 64'd0);
    wa = rand_word();
    send(0, wa);
    wait_end(0, end_cnt[0] + 1, 3000);
    done0_exp++;
    check_frame0("after_rst", wa);
    chk("done_count_final", 64'(done_cnt[0]), 64'(done0_exp));
    chk("done_in_gap0", 64'(viol_done[0]), 64'd0);
    chk("sclk_quiet_nss_high0", 64'(viol_sclk[0]), 64'd0);

    // long hold, loopback field decode
    wa = 60'hABC_DEF0_1234_5678;
    send(1, wa);
    wait_end(1, end_cnt[1] + 1, 5000);
    chk("hold_count", 64'(fq1.size()), 64'd1);
    if (fq1.size() > 0) begin
      wb = fq1.pop_front();
      chk("adsr_ai",   field(wb, ADSR_AI_LSB,   ADSR_AI_W),   64'h78);
      chk("adsr_di",   field(wb, ADSR_DI_LSB,   ADSR_DI_W),   64'h56);
      chk("adsr_s",    field(wb, ADSR_S_LSB,    ADSR_S_W),    64'h34);
      chk("adsr_ri",   field(wb, ADSR_RI_LSB,   ADSR_RI_W),   64'h12);
      chk("osc_count", field(wb, OSC_COUNT_LSB, OSC_COUNT_W), 64'hEF0);
      chk("filter_a",  field(wb, FILTER_A_LSB,  FILTER_A_W),  64'hCD);
      chk("filter_b",  field(wb, FILTER_B_LSB,  FILTER_B_W),  64'hAB);
    end
    chk("hold_nss_low", 64'(end_len[1]), 64'(DIV1 + 2 * DIV1 * W + HOLD1));
    chk("hold_edges", 64'(end_edges[1]), 64'(W));
    chk("hold_sclk_quiet", 64'((end_len[1] - end_tog[1]) >= HOLD1), 64'd1);
    chk("hold_mosi_stable", 64'(viol_mosi[1]), 64'd0);
    chk("hold_done_count", 64'(done_cnt[1]), 64'd1);
    chk("done_in_gap1", 64'(viol_done[1]), 64'd0);
    chk("sclk_quiet_nss_high1", 64'(viol_sclk[1]), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
